// File: rtl/cache_pkg.sv
// Shared definitions for the cache controller's system-side path:
// bus direction encodings, default memory timing and the drain FSM states.
package cache_pkg;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    localparam int DEFAULT_WAITSTATES = 2;

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        WR_WAIT,
        RD_ISSUE,
        RD_WAIT,
        RD_DONE
    } drainState_t;

endpackage

// File: rtl/sys_wait_counter.sv
// Loadable down-counter timing memory wait states; Carry marks the last wait
// cycle (count == 1) so the access can complete on that cycle.
module sys_wait_counter
    import cache_pkg::*;
#(
    parameter int WAITSTATES = DEFAULT_WAITSTATES
) (
    input  logic                               Clk,
    input  logic                               Reset,
    input  logic                               Load,
    input  logic [$clog2(WAITSTATES+1)-1:0]    LoadValue,
    output logic                               Carry
);

    localparam int CNT_W = $clog2(WAITSTATES + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            count <= '0;
        end else if (Load) begin
            count <= LoadValue;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign Carry = (count == CNT_W'(1));

endmodule

// File: rtl/sys_write_buffer.sv
// Posted write buffer: queues write-through stores with a one-cycle acknowledge
// and drains them to memory; reads wait for the queue to empty, then hit memory.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | no access in flight; pick queued write first, else read
//   WR_ISSUE | SysStrobe for the head entry, wait counter loaded
//   WR_WAIT  | write held on the bus; pop head on the carry cycle
//   RD_ISSUE | SysStrobe for the pending controller read
//   RD_WAIT  | read held on the bus; capture SysDataIn on the carry cycle
//   RD_DONE  | CReady pulse returning the read data
module sys_write_buffer
    import cache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 4,
    parameter int WAITSTATES = DEFAULT_WAITSTATES
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      CStrobe,
    input  logic                      CRW,
    input  logic [ADDR_W-1:0]         CAddr,
    input  logic [DATA_W-1:0]         CDataIn,
    output logic                      CReady,
    output logic [DATA_W-1:0]         CDataOut,
    output logic                      SysStrobe,
    output logic                      SysRW,
    output logic [ADDR_W-1:0]         SysAddr,
    output logic [DATA_W-1:0]         SysDataOut,
    output logic                      SysDataOE,
    input  logic [DATA_W-1:0]         SysDataIn,
    output logic                      BufEmpty,
    output logic [$clog2(DEPTH):0]    BufCount
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int WC_W  = $clog2(WAITSTATES + 1);

    logic [ADDR_W-1:0] fifoAddr [DEPTH];
    logic [DATA_W-1:0] fifoData [DEPTH];
    logic [PTR_W-1:0]  wrPtr, rdPtr;
    logic [CNT_W-1:0]  count;

    drainState_t state, nextState;
    logic        writeAck;
    logic        writeAccept, readPending, pop;
    logic        waitLoad, waitCarry;

    // Registered count gates acceptance, so a same-cycle pop cannot make room.
    assign writeAccept = CStrobe && (CRW == WRITE) && !CReady && (count < CNT_W'(DEPTH));
    assign readPending = CStrobe && (CRW == READ) && !CReady;
    assign pop         = (state == WR_WAIT) && waitCarry;
    assign waitLoad    = (state == WR_ISSUE) || (state == RD_ISSUE);

    sys_wait_counter #(.WAITSTATES(WAITSTATES)) waitCounter (
        .Clk       (Clk),
        .Reset     (Reset),
        .Load      (waitLoad),
        .LoadValue (WC_W'(WAITSTATES)),
        .Carry     (waitCarry)
    );

    always_ff @(posedge Clk) begin
        if (writeAccept) begin
            fifoAddr[wrPtr] <= CAddr;
            fifoData[wrPtr] <= CDataIn;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            writeAck <= 1'b0;
        end else begin
            writeAck <= writeAccept;
            if (writeAccept) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)         rdPtr <= rdPtr + PTR_W'(1);
            case ({writeAccept, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    nextState = WR_ISSUE;
                end else if (readPending) begin
                    nextState = RD_ISSUE;
                end
            end
            WR_ISSUE: nextState = WR_WAIT;
            WR_WAIT:  if (waitCarry) nextState = IDLE;
            RD_ISSUE: nextState = RD_WAIT;
            RD_WAIT:  if (waitCarry) nextState = RD_DONE;
            RD_DONE:  nextState = IDLE;
            default:  nextState = IDLE;
        endcase
    end

    // Bus fields are latched on the way into an issue state and held until the next access.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            SysRW      <= READ;
            SysAddr    <= '0;
            SysDataOut <= '0;
            CDataOut   <= '0;
        end else begin
            if (state == IDLE && nextState == WR_ISSUE) begin
                SysRW      <= WRITE;
                SysAddr    <= fifoAddr[rdPtr];
                SysDataOut <= fifoData[rdPtr];
            end else if (state == IDLE && nextState == RD_ISSUE) begin
                SysRW   <= READ;
                SysAddr <= CAddr;
            end
            if (state == RD_WAIT && waitCarry) begin
                CDataOut <= SysDataIn;
            end
        end
    end

    assign SysStrobe = waitLoad;
    assign SysDataOE = (state == WR_ISSUE) || (state == WR_WAIT);
    assign CReady    = writeAck || (state == RD_DONE);
    assign BufEmpty  = (count == '0) && (state == IDLE);
    assign BufCount  = count;

endmodule
